// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_pkg : shared datapath constants and the IF/ID bundle type         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR_WORD   = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

endpackage

`default_nettype wire

// File: rtl/ifid_reg.sv
// +----------------------------------------------------------------------+
// | ifid_reg : IF/ID pipeline register, priority flush > hold > load      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_write,
    input  logic [XLEN-1:0] i_pc_plus4,
    input  logic [XLEN-1:0] i_instr,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic [XLEN-1:0] o_instr,
    output logic            o_valid
);

    ifid_t r_ifid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid.pc_plus4 <= '0;
            r_ifid.instr    <= NOP_INSTR;
            r_ifid.valid    <= 1'b0;
        end else if (i_flush) begin
            r_ifid.pc_plus4 <= '0;
            r_ifid.instr    <= NOP_INSTR;
            r_ifid.valid    <= 1'b0;
        end else if (i_write) begin
            r_ifid.pc_plus4 <= i_pc_plus4;
            r_ifid.instr    <= i_instr;
            r_ifid.valid    <= 1'b1;
        end
    end

    assign o_pc_plus4 = r_ifid.pc_plus4;
    assign o_instr    = r_ifid.instr;
    assign o_valid    = r_ifid.valid;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// +----------------------------------------------------------------------+
// | if_stage : MIPS fetch stage - PC, PC+4, redirect mux, IF/ID register  |
// | Optional IF_PERF_CNT_EN adds saturating stall/flush counters.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module if_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pc_write_i,
    input  logic            ifid_write_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_data_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] ifid_pc_plus4_o,
    output logic [XLEN-1:0] ifid_instr_o,
`ifdef IF_PERF_CNT_EN
    output logic [XLEN-1:0] stall_cnt_o,
    output logic [XLEN-1:0] flush_cnt_o,
`endif
    output logic            ifid_valid_o
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_next_pc;
    logic            w_redirect;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_redirect = branch_taken_i | jump_i;

    // Branch resolves in EX and so belongs to the older instruction than a jump in ID.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (branch_taken_i) begin
            w_next_pc = branch_target_i;
        end else if (jump_i) begin
            w_next_pc = jump_target_i;
        end
    end

    // A redirect squashes the stalled instruction, so it ignores pc_write_i.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc <= RESET_PC;
        end else if (w_redirect || pc_write_i) begin
            r_pc <= w_next_pc;
        end
    end

    assign imem_addr_o = r_pc;
    assign pc_o        = r_pc;

    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .i_flush    (w_redirect),
        .i_write    (ifid_write_i),
        .i_pc_plus4 (w_pc_plus4),
        .i_instr    (imem_data_i),
        .o_pc_plus4 (ifid_pc_plus4_o),
        .o_instr    (ifid_instr_o),
        .o_valid    (ifid_valid_o)
    );

`ifdef IF_PERF_CNT_EN
    logic [XLEN-1:0] r_stall_cnt;
    logic [XLEN-1:0] r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write_i && !w_redirect && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, PC+4 adder, redirect mux and the IF/ID pipeline register.
- Consumes PCWrite / IFID_Write from the hazard unit, and branch/jump redirects from ID/EX.
- Drives the instruction-memory address and presents {pc_plus4, instr, valid} to the decode stage and the hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on flush or reset (sll $0,$0,0).

Ports:
- clk_i  in  1  rising-edge clock
- rst_i  in  1  asynchronous active-low reset
- pc_write_i  in  1  1 = PC may update; 0 = hold PC (load-use stall)
- ifid_write_i  in  1  1 = IF/ID may load; 0 = hold IF/ID
- branch_taken_i  in  1  branch resolved taken (EX); redirect plus flush
- branch_target_i  in  32  branch target address
- jump_i  in  1  j/jal decoded in ID; redirect plus flush
- jump_target_i  in  32  jump target address
- imem_addr_o  out  32  current PC, to combinational instruction memory
- imem_data_i  in  32  instruction word at imem_addr_o, same cycle
- pc_o  out  32  current PC (debug/trace)
- ifid_pc_plus4_o  out  32  registered PC+4 of the instruction in ID
- ifid_instr_o  out  32  registered instruction in ID
- ifid_valid_o  out  1  0 = ID holds a bubble

Behaviour:
- Reset (rst_i=0, async): PC=RESET_PC, ifid_pc_plus4_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0. First fetch occurs in the first clock after release. PC is held while reset is asserted, including mid-operation.
- imem_addr_o = pc_o = PC, combinational from the register. Fetch latency is 1 cycle: the instruction fetched in cycle N appears on the IF/ID outputs in cycle N+1.
- next_pc selection, highest priority first:
  - branch_taken_i -> branch_target_i
  - jump_i -> jump_target_i
  - otherwise PC+4
- PC+4 is a 32-bit add that wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- PC update: if branch_taken_i or jump_i, PC <= next_pc regardless of pc_write_i. A redirect overrides a stall, because the stalled instruction is being squashed.
  - Else if pc_write_i, PC <= PC+4.
  - Else PC holds.
- IF/ID update:
  - Flush (branch_taken_i or jump_i): instr <= NOP_INSTR, valid <= 0, pc_plus4 <= 0. Flush has priority over ifid_write_i=0.
  - Else if ifid_write_i: instr <= imem_data_i, pc_plus4 <= PC+4, valid <= 1.
  - Else hold all three.
- Branch and jump in the same cycle: the branch target wins (older instruction). A single flush is counted.
- pc_write_i=0 with ifid_write_i=1 is legal: the same PC is refetched and IF/ID reloads the same word.
- No internal state beyond the registers listed here. No handshake with instruction memory; it is assumed zero-wait.

Optional Feature:
- Macro IF_PERF_CNT_EN adds two ports: stall_cnt_o (32) and flush_cnt_o (32). Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - stall_cnt_o increments every cycle with pc_write_i=0 and no redirect.
  - flush_cnt_o increments every cycle with branch_taken_i or jump_i.
- Without the macro, the ports and counters are absent and the behaviour above is unchanged.

Decomposition:
- Shared package cpu_pkg holds:
  - constants XLEN=32, NOP_INSTR value, RESET_PC default
  - typedef ifid_t {pc_plus4, instr, valid}, reused by the ID stage and the hazard unit
- One natural sub-module: ifid_reg, the IF/ID register with write-enable and flush inputs, priority flush > hold > load.

Test Plan:
- Reset then free-run 4 cycles, imem returns addr+32'h1000 -> imem_addr 0,4,8,C; ifid_instr lags by 1 cycle; valid=1 from cycle 2.
- pc_write_i=0 and ifid_write_i=0 for 2 cycles at PC=8 -> PC stays 8; ifid_instr and ifid_pc_plus4=8 hold; resumes to C afterwards.
- branch_taken_i=1, target 0x40, during a stall -> next PC=0x40; IF/ID = NOP, valid=0; the following cycle fetches 0x40.
- branch_taken_i and jump_i together, targets 0x80 and 0x100 -> PC=0x80; one flush.
- PC preset via branch to 32'hFFFF_FFFC, free-run -> next PC=0; ifid_pc_plus4=0.
- Assert rst_i low mid-run at PC=0x20 -> PC=RESET_PC and IF/ID=NOP, valid=0 immediately, before the next clock edge; with IF_PERF_CNT_EN, counters also read 0.
